// File: rtl/stopwatch_ctrl.sv
// Debounces the three stopwatch buttons and sequences the digit datapath through STOP/RUN/SET0..SET3.
// Optional macro STOPWATCH_CTRL_SET_TIMEOUT_EN: leave set mode after SET_TIMEOUT_CYC idle cycles.
module stopwatch_ctrl #(
  parameter int TICK_DIV        = 1000000,
  parameter int DEBOUNCE_CYC    = 16,
  parameter int SET_TIMEOUT_CYC = 500000000
) (
  input  logic       clk100_i,
  input  logic       rst_i,
  input  logic       start_stop_i,
  input  logic       set_i,
  input  logic       change_i,
  output logic       tick_o,
  output logic       clear_o,
  output logic       digit_inc_o,
  output logic [1:0] digit_sel_o,
  output logic       run_o,
  output logic       set_mode_o
);

  typedef enum logic [2:0] {ST_STOP, ST_RUN, ST_SET0, ST_SET1, ST_SET2, ST_SET3} state_t;

  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

  // Bit order for all button vectors: 0 = start_stop, 1 = set, 2 = change.
  logic [2:0]    raw, sync1, sync2, deb, deb_d, armed, press_q;
  logic [CW-1:0] cnt [3];

  assign raw = {change_i, set_i, start_stop_i};

  always_ff @(posedge clk100_i) begin
    sync1 <= raw;
    sync2 <= sync1;
  end

  // A button is armed only once it has been seen released, so a hold through reset never counts as a press.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      deb     <= '1;
      deb_d   <= '1;
      armed   <= '0;
      press_q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      deb_d   <= deb;
      press_q <= deb_d & ~deb & armed;
      armed   <= armed | (deb & sync2);
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic ss_p, set_p, chg_p;
  assign ss_p  = press_q[0];
  assign set_p = press_q[1] & ~press_q[0];
  assign chg_p = press_q[2] & ~press_q[1] & ~press_q[0];

  state_t        state, state_nxt;
  logic          clear_nxt, inc_nxt, set_nxt;
  logic [1:0]    sel_nxt;
  logic [DW-1:0] div;

`ifdef STOPWATCH_CTRL_SET_TIMEOUT_EN
  localparam int IW = $clog2(SET_TIMEOUT_CYC);
  localparam logic [IW-1:0] IDLE_MAX = IW'(SET_TIMEOUT_CYC - 1);
  logic [IW-1:0] idle;
  logic          in_set;
  assign in_set = (state == ST_SET0) || (state == ST_SET1) || (state == ST_SET2) || (state == ST_SET3);
`endif

  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    inc_nxt   = 1'b0;
    case (state)
      ST_STOP: begin
        if (ss_p)       state_nxt = ST_RUN;
        else if (set_p) state_nxt = ST_SET0;
        else if (chg_p) clear_nxt = 1'b1;
      end
      ST_RUN:  if (ss_p) state_nxt = ST_STOP;
      ST_SET0: if (set_p) state_nxt = ST_SET1; else if (chg_p) inc_nxt = 1'b1;
      ST_SET1: if (set_p) state_nxt = ST_SET2; else if (chg_p) inc_nxt = 1'b1;
      ST_SET2: if (set_p) state_nxt = ST_SET3; else if (chg_p) inc_nxt = 1'b1;
      ST_SET3: if (set_p) state_nxt = ST_STOP; else if (chg_p) inc_nxt = 1'b1;
      default: state_nxt = ST_STOP;
    endcase
`ifdef STOPWATCH_CTRL_SET_TIMEOUT_EN
    if (in_set && (idle == IDLE_MAX) && (press_q == 3'b000)) state_nxt = ST_STOP;
`endif
    set_nxt = 1'b1;
    case (state_nxt)
      ST_SET0: sel_nxt = 2'd0;
      ST_SET1: sel_nxt = 2'd1;
      ST_SET2: sel_nxt = 2'd2;
      ST_SET3: sel_nxt = 2'd3;
      default: begin
        sel_nxt = 2'd0;
        set_nxt = 1'b0;
      end
    endcase
  end

  // Outputs are registered from next-state so they switch on the same edge as the state.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      state       <= ST_STOP;
      run_o       <= 1'b0;
      set_mode_o  <= 1'b0;
      digit_sel_o <= 2'd0;
      digit_inc_o <= 1'b0;
      clear_o     <= 1'b0;
      tick_o      <= 1'b0;
      div         <= '0;
    end else begin
      state       <= state_nxt;
      run_o       <= (state_nxt == ST_RUN);
      set_mode_o  <= set_nxt;
      digit_sel_o <= sel_nxt;
      digit_inc_o <= inc_nxt;
      clear_o     <= clear_nxt;
      tick_o      <= (state == ST_RUN) && (div == DIV_MAX) && (state_nxt == ST_RUN);
      if (clear_nxt)                               div <= '0;
      else if (state == ST_RUN && div == DIV_MAX)  div <= '0;
      else if (state == ST_RUN)                    div <= div + 1'b1;
    end
  end

`ifdef STOPWATCH_CTRL_SET_TIMEOUT_EN
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      idle <= '0;
    end else if (!in_set || (state_nxt != state) || (press_q != 3'b000)) begin
      idle <= '0;
    end else begin
      idle <= idle + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected pulses queued at stimulus time, matched by a negedge monitor.
module tb_stopwatch_ctrl;

  localparam int TDIV = 10;
  localparam int DEB  = 4;
  localparam int TO   = 200;
  localparam int LAT  = DEB + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_n;
  logic       tick_o, clear_o, digit_inc_o, run_o, set_mode_o;
  logic [1:0] digit_sel_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int sel;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  stopwatch_ctrl #(.TICK_DIV(TDIV), .DEBOUNCE_CYC(DEB), .SET_TIMEOUT_CYC(TO)) dut (
    .clk100_i    (clk),
    .rst_i       (rst),
    .start_stop_i(btn_n[0]),
    .set_i       (btn_n[1]),
    .change_i    (btn_n[2]),
    .tick_o      (tick_o),
    .clear_o     (clear_o),
    .digit_inc_o (digit_inc_o),
    .digit_sel_o (digit_sel_o),
    .run_o       (run_o),
    .set_mode_o  (set_mode_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int k, input int s, input int c);
    ev_t e;
    e.kind = k;
    e.sel  = s;
    e.cyc  = c;
    return e;
  endfunction

  // kind 0 = tick, 1 = clear, 2 = digit_inc
  always @(negedge clk) begin
    logic p;
    ev_t  e;
    for (int k = 0; k < 3; k++) begin
      p = (k == 0) ? tick_o : (k == 1) ? clear_o : digit_inc_o;
      if (p === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: kind %0d at cycle %0d, none expected", k, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.cyc != cyc || (k == 2 && e.sel != int'(digit_sel_o))) begin
            errors++;
            $display("FAIL pulse: got kind %0d sel %0d cycle %0d, expected kind %0d sel %0d cycle %0d",
                     k, digit_sel_o, cyc, e.kind, e.sel, e.cyc);
          end
        end
      end
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) cyc_wait(1);
  endtask

  task automatic test_reset;
    int t0;
    bit seen;
    rst = 1'b1;
    btn_n = 3'b110;
    cyc_wait(3);
    rst = 1'b0;
    cyc_wait(1);
    checks++;
    if ({tick_o, clear_o, digit_inc_o, digit_sel_o, run_o, set_mode_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 0000000",
               {tick_o, clear_o, digit_inc_o, digit_sel_o, run_o, set_mode_o});
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc_wait(1);
      if (run_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL held_through_reset: run_o went 1, expected 0");
    end
    btn_n[0] = 1'b1;
    cyc_wait(12);
    btn_n[0] = 1'b0;
    t0 = cyc;
    wait_until(t0 + LAT - 1);
    checks++;
    if (run_o !== 1'b0) begin
      errors++;
      $display("FAIL run_early: run_o %b, expected 0", run_o);
    end
    wait_until(t0 + LAT);
    checks++;
    if (run_o !== 1'b1 || set_mode_o !== 1'b0) begin
      errors++;
      $display("FAIL run_latency: run_o %b set_mode_o %b, expected 1 0", run_o, set_mode_o);
    end
    wait_until(t0 + 12);
    btn_n[0] = 1'b1;
    wait_until(t0 + 13);
    rst = 1'b1;
    cyc_wait(1);
    checks++;
    if ({tick_o, clear_o, digit_inc_o, digit_sel_o, run_o, set_mode_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_midrun: got %b, expected 0000000",
               {tick_o, clear_o, digit_inc_o, digit_sel_o, run_o, set_mode_o});
    end
    cyc_wait(2);
    rst = 1'b0;
    cyc_wait(10);
  endtask

  task automatic test_glitch;
    int t0;
    btn_n[1] = 1'b0;
    cyc_wait(3);
    btn_n[1] = 1'b1;
    cyc_wait(15);
    checks++;
    if (set_mode_o !== 1'b0) begin
      errors++;
      $display("FAIL glitch: set_mode_o %b, expected 0", set_mode_o);
    end
    btn_n[1] = 1'b0;
    t0 = cyc;
    wait_until(t0 + LAT - 1);
    checks++;
    if (set_mode_o !== 1'b0) begin
      errors++;
      $display("FAIL set_early: set_mode_o %b, expected 0", set_mode_o);
    end
    wait_until(t0 + LAT);
    checks++;
    if (set_mode_o !== 1'b1 || digit_sel_o !== 2'd0) begin
      errors++;
      $display("FAIL set_latency: set_mode_o %b sel %0d, expected 1 0", set_mode_o, digit_sel_o);
    end
    wait_until(t0 + 20);
    btn_n[1] = 1'b1;
    cyc_wait(10);
  endtask

  task automatic test_set_sequence;
    int t;
    for (int n = 0; n < 4; n++) begin
      btn_n[2] = 1'b0;
      t = cyc;
      exp_q.push_back(mk(2, n, t + LAT));
      cyc_wait(8);
      btn_n[2] = 1'b1;
      cyc_wait(10);
      checks++;
      if (set_mode_o !== 1'b1 || int'(digit_sel_o) != n) begin
        errors++;
        $display("FAIL set_digit%0d: set_mode_o %b sel %0d, expected 1 %0d", n, set_mode_o, digit_sel_o, n);
      end
      btn_n[1] = 1'b0;
      cyc_wait(8);
      btn_n[1] = 1'b1;
      cyc_wait(10);
      checks++;
      if (n < 3) begin
        if (set_mode_o !== 1'b1 || int'(digit_sel_o) != n + 1) begin
          errors++;
          $display("FAIL set_advance%0d: set_mode_o %b sel %0d, expected 1 %0d", n, set_mode_o, digit_sel_o, n + 1);
        end
      end else if (set_mode_o !== 1'b0 || run_o !== 1'b0 || digit_sel_o !== 2'd0) begin
        errors++;
        $display("FAIL set_exit: set_mode_o %b run_o %b sel %0d, expected 0 0 0", set_mode_o, run_o, digit_sel_o);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL set_pending: %0d pulses missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_run;
    int t0, t1, t2, t3;
    btn_n[0] = 1'b0;
    t0 = cyc;
    exp_q.push_back(mk(0, 0, t0 + LAT + TDIV));
    exp_q.push_back(mk(0, 0, t0 + LAT + 2 * TDIV));
    wait_until(t0 + LAT);
    checks++;
    if (run_o !== 1'b1) begin
      errors++;
      $display("FAIL run_start: run_o %b, expected 1", run_o);
    end
    btn_n[0] = 1'b1;
    wait_until(t0 + 25);
    btn_n[0] = 1'b0;
    t1 = cyc;
    wait_until(t1 + LAT - 1);
    checks++;
    if (run_o !== 1'b1) begin
      errors++;
      $display("FAIL run_hold: run_o %b, expected 1", run_o);
    end
    wait_until(t1 + LAT);
    checks++;
    if (run_o !== 1'b0) begin
      errors++;
      $display("FAIL run_stop: run_o %b, expected 0", run_o);
    end
    btn_n[0] = 1'b1;
    wait_until(t1 + 20);
    btn_n[0] = 1'b0;
    t2 = cyc;
    exp_q.push_back(mk(0, 0, t2 + LAT + 5));
    exp_q.push_back(mk(0, 0, t2 + LAT + 15));
    wait_until(t2 + LAT);
    btn_n[0] = 1'b1;
    wait_until(t2 + 9);
    btn_n[1] = 1'b0;
    btn_n[2] = 1'b0;
    wait_until(t2 + 17);
    btn_n[1] = 1'b1;
    btn_n[2] = 1'b1;
    wait_until(t2 + 20);
    checks++;
    if (run_o !== 1'b1 || set_mode_o !== 1'b0) begin
      errors++;
      $display("FAIL run_ignore: run_o %b set_mode_o %b, expected 1 0", run_o, set_mode_o);
    end
    btn_n[0] = 1'b0;
    t3 = cyc;
    wait_until(t3 + LAT);
    checks++;
    if (run_o !== 1'b0) begin
      errors++;
      $display("FAIL run_stop2: run_o %b, expected 0", run_o);
    end
    btn_n[0] = 1'b1;
    wait_until(t3 + 20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_pending: %0d pulses missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_clear;
    int t;
    btn_n[2] = 1'b0;
    t = cyc;
    exp_q.push_back(mk(1, 0, t + LAT));
    wait_until(t + LAT);
    btn_n[2] = 1'b1;
    cyc_wait(12);
    checks++;
    if (exp_q.size() != 0 || run_o !== 1'b0) begin
      errors++;
      $display("FAIL clear: pending %0d run_o %b, expected 0 0", exp_q.size(), run_o);
    end
  endtask

  task automatic test_simultaneous;
    int t, t4;
    btn_n[0] = 1'b0;
    btn_n[2] = 1'b0;
    t = cyc;
    exp_q.push_back(mk(0, 0, t + LAT + TDIV));
    exp_q.push_back(mk(0, 0, t + LAT + 2 * TDIV));
    wait_until(t + LAT);
    checks++;
    if (run_o !== 1'b1) begin
      errors++;
      $display("FAIL simul_run: run_o %b, expected 1", run_o);
    end
    btn_n[0] = 1'b1;
    btn_n[2] = 1'b1;
    wait_until(t + 22);
    btn_n[0] = 1'b0;
    t4 = cyc;
    wait_until(t4 + LAT);
    checks++;
    if (run_o !== 1'b0) begin
      errors++;
      $display("FAIL simul_stop: run_o %b, expected 0", run_o);
    end
    btn_n[0] = 1'b1;
    wait_until(t4 + 20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simul_pending: %0d pulses missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_timeout;
    int t, s;
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      btn_n[1] = 1'b0;
      t = cyc;
      wait_until(t + LAT);
      btn_n[1] = 1'b1;
      if (k < 2) wait_until(t + 16);
    end
    s = t + LAT;
    checks++;
    if (set_mode_o !== 1'b1 || digit_sel_o !== 2'd2) begin
      errors++;
      $display("FAIL to_enter: set_mode_o %b sel %0d, expected 1 2", set_mode_o, digit_sel_o);
    end
`ifdef STOPWATCH_CTRL_SET_TIMEOUT_EN
    wait_until(s + TO - 1);
    checks++;
    if (set_mode_o !== 1'b1) begin
      errors++;
      $display("FAIL to_early: set_mode_o %b, expected 1", set_mode_o);
    end
    wait_until(s + TO);
    checks++;
    if (set_mode_o !== 1'b0 || digit_sel_o !== 2'd0 || run_o !== 1'b0) begin
      errors++;
      $display("FAIL to_exit: set_mode_o %b sel %0d run_o %b, expected 0 0 0", set_mode_o, digit_sel_o, run_o);
    end
`else
    wait_until(s + 1000);
    checks++;
    if (set_mode_o !== 1'b1 || digit_sel_o !== 2'd2) begin
      errors++;
      $display("FAIL no_timeout: set_mode_o %b sel %0d, expected 1 2", set_mode_o, digit_sel_o);
    end
    for (int k = 0; k < 2; k++) begin
      btn_n[1] = 1'b0;
      cyc_wait(8);
      btn_n[1] = 1'b1;
      cyc_wait(10);
    end
    checks++;
    if (set_mode_o !== 1'b0) begin
      errors++;
      $display("FAIL to_manual_exit: set_mode_o %b, expected 0", set_mode_o);
    end
`endif
    cyc_wait(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL to_pending: %0d pulses missing, expected 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_n = 3'b110;
    test_reset();
    test_glitch();
    test_set_sequence();
    test_run();
    test_clear();
    test_simultaneous();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
